// File: rtl/fp_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier: 24-step shift-and-add mantissa
// product, then truncating normalise/pack with zero, underflow and overflow handling.
module fp_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    // Handshake: the core holds run high and x/y stable; while stall is high it
    // freezes. The cycle stall is low with run high, z holds the finished product.

    logic [4:0]  s;
    logic [47:0] p;

    logic        sign;
    logic [7:0]  xe;
    logic [7:0]  ye;
    logic [23:0] mx;
    logic [23:0] my;
    logic [23:0] my_shift;
    logic [24:0] sum;
    logic [9:0]  e;
    logic [22:0] f;
    logic [31:0] packed_z;

    assign sign  = x[31] ^ y[31];
    assign xe    = x[30:23];
    assign ye    = y[30:23];
    assign mx    = {1'b1, x[22:0]};
    assign my    = {1'b1, y[22:0]};
    assign stall = run & (s != 5'd25);

    always_comb begin
        my_shift = my >> s;
        sum      = ((s == 5'd0) ? 25'd0 : {1'b0, p[47:24]})
                 + (my_shift[0] ? {1'b0, mx} : 25'd0);
    end

    // P[47] set means the product is in [2,4): take one more exponent step.
    always_comb begin
        e = {2'b00, xe} + {2'b00, ye} - 10'd127 + {9'd0, p[47]};
        f = p[47] ? p[46:24] : p[45:23];
        if (xe == 8'd0 || ye == 8'd0) begin
            packed_z = 32'd0;
        end else if ($signed(e) <= 10'sd0) begin
            packed_z = 32'd0;
        end else if ($signed(e) >= 10'sd255) begin
            packed_z = {sign, 8'hFF, 23'd0};
        end else begin
            packed_z = {sign, e[7:0], f};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 5'd0;
            p <= 48'd0;
            z <= 32'd0;
        end else if (!run) begin
            s <= 5'd0;
        end else begin
            if (s != 5'd25) begin
                s <= s + 5'd1;
            end
            // Shifting {sum, P[23:0]} right by one drops the retired low bit.
            if (s < 5'd24) begin
                p <= {sum, ((s == 5'd0) ? 23'd0 : p[23:1])};
            end
            if (s == 5'd24) begin
                z <= packed_z;
            end
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: directed corner cases, control scenarios
// and random operands compared against an arithmetic reference model.
module tb_fp_multiplier;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    fp_multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then the IEEE packing rules.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, prod;
        int ea, eb, ex, carry;
        logic [31:0] frac;
        logic sg;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return 32'd0;
        ma = 64'h800000 + longint'(a[22:0]);
        mb = 64'h800000 + longint'(b[22:0]);
        prod = ma * mb;
        carry = (prod >= 64'h8000_0000_0000) ? 1 : 0;
        ex = ea + eb - 127 + carry;
        frac = 32'((carry == 1) ? (prod >> 24) : (prod >> 23)) & 32'h7FFFFF;
        if (ex <= 0) return 32'd0;
        if (ex >= 255) return {sg, 8'hFF, 23'd0};
        return {sg, ex[7:0], frac[22:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full operation, checks stall length and the result, leaves run high.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        x = a;
        y = b;
        run = 1'b1;
        #1;
        exp_q.push_back(ref_mul(a, b));
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_stall_len"}, 32'(n), 32'd25);
        check({tag, "_z"}, z, exp_q.pop_front());
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        start_and_wait(a, b, tag);
        run = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] z_prev;
        rst = 1'b1;
        run = 1'b0;
        x = 32'd0;
        y = 32'd0;
        tick();
        tick();
        check("reset_z", z, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        tick();

        do_op(32'h3FC00000, 32'h40000000, "basic");
        check("basic_value", z, 32'h40400000);
        do_op(32'hC0000000, 32'h40400000, "neg");
        check("neg_value", z, 32'hC0C00000);
        do_op(32'h3F800000, 32'h3F800000, "one");
        check("one_value", z, 32'h3F800000);
        do_op(32'h3FFFFFFF, 32'h3FFFFFFF, "carry");
        check("carry_value", z, 32'h407FFFFE);
        do_op(32'h00000000, 32'h40A00000, "zero");
        do_op(32'h00800000, 32'h00800000, "underflow");
        do_op(32'h80000000, 32'hC0000000, "negzero");
        do_op(32'h7F000000, 32'h7F000000, "ovf");
        check("ovf_value", z, 32'h7F800000);
        do_op(32'hFF000000, 32'h7F000000, "novf");
        check("novf_value", z, 32'hFF800000);

        // Reset in the middle of an operation, run kept high.
        do_op(32'h40400000, 32'h40400000, "pre_rst");
        x = 32'h3FC00000;
        y = 32'h40800000;
        run = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("midrst_z", z, 32'd0);
        rst = 1'b0;
        start_and_wait(32'h3FC00000, 32'h40800000, "after_rst");
        run = 1'b0;
        tick();

        // Abandon at S=12: stall drops at once, z keeps its old value.
        z_prev = z;
        x = 32'h40A00000;
        y = 32'h40A00000;
        run = 1'b1;
        repeat (12) tick();
        run = 1'b0;
        #1;
        check("abandon_stall", {31'd0, stall}, 32'd0);
        repeat (15) tick();
        check("abandon_z", z, z_prev);

        // Run held past completion.
        start_and_wait(32'h40E00000, 32'hBF000000, "hold");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_stall", {31'd0, stall}, 32'd0);
            check("hold_z", z, 32'hC0600000);
        end
        run = 1'b0;
        tick();

        // Random operands; exponent picked to exercise normal, zero, under/overflow.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a[30:23] = 8'($urandom_range(100, 154));
                1: a[30:23] = 8'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) b[30:23] = 8'(254 - int'(a[30:23]) / 2 + $urandom_range(0, 120));
            do_op(a, b, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
